// File: rtl/alu_simple.sv
// 32-bit registered ALU with barrel shifter for the execute stage.
// Rotate ops are built only when ALU_ROTATE_EN is defined.
module alu_simple #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       opcode,
  input  logic [4:0]       SR_Bit,
  input  logic [2:0]       SR_Cont,
  output logic [WIDTH-1:0] Out
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;

  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_SRL  = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_ROR  = 3'b011;
  localparam logic [2:0] SH_ROL  = 3'b100;
  localparam logic [2:0] SH_SRA  = 3'b101;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   sh_res;
  logic [WIDTH-1:0]   out_d;
  logic [WIDTH-1:0]   out_q;
  logic [2*WIDTH-1:0] prod;

  assign prod = In1 * In2;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (opcode == OP_ADD): alu_res = In1 + In2;
      (opcode == OP_SUB): alu_res = In1 - In2;
      (opcode == OP_MUL): alu_res = prod[WIDTH-1:0];
      (opcode == OP_OR):  alu_res = In1 | In2;
      (opcode == OP_AND): alu_res = In1 & In2;
      (opcode == OP_XOR): alu_res = In1 ^ In2;
      default:            alu_res = '0;
    endcase
  end

`ifdef ALU_ROTATE_EN
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_r;
  logic [2*WIDTH-1:0] dbl_l;
  logic [WIDTH-1:0]   ror_res;
  logic [WIDTH-1:0]   rol_res;

  // Doubling the word turns a rotate into a plain shift of the pair.
  assign dbl     = {In2, In2};
  assign dbl_r   = dbl >> SR_Bit;
  assign dbl_l   = dbl << SR_Bit;
  assign ror_res = dbl_r[WIDTH-1:0];
  assign rol_res = dbl_l[2*WIDTH-1:WIDTH];
`else
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] rol_res;

  assign ror_res = '0;
  assign rol_res = '0;
`endif

  always_comb begin
    sh_res = '0;
    unique case (1'b1)
      (SR_Cont == SH_SRL): sh_res = In2 >> SR_Bit;
      (SR_Cont == SH_SLL): sh_res = In2 << SR_Bit;
      (SR_Cont == SH_ROR): sh_res = ror_res;
      (SR_Cont == SH_ROL): sh_res = rol_res;
      (SR_Cont == SH_SRA): sh_res = $unsigned($signed(In2) >>> SR_Bit);
      default:             sh_res = '0;
    endcase
  end

  // Any nonzero shift control overrides the opcode.
  assign out_d = (SR_Cont == SH_NONE) ? alu_res : sh_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_alu_simple.sv
// Scoreboard bench for alu_simple.
// Build with ALU_ROTATE_EN defined to expect rotate results.
module tb_alu_simple;

  logic        clk;
  logic        rst_n;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  opcode;
  logic [4:0]  SR_Bit;
  logic [2:0]  SR_Cont;
  logic [31:0] Out;

  int n_tests;
  int n_fail;
  logic [31:0] sb_q[$];

  alu_simple dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .In1    (In1),
    .In2    (In2),
    .opcode (opcode),
    .SR_Bit (SR_Bit),
    .SR_Cont(SR_Cont),
    .Out    (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
    input logic [2:0] sc, input logic [4:0] sb);
    logic [31:0] r;
    logic [63:0] p;
    int s;
    r = '0;
    s = int'(sb);
    if (sc == 3'd0) begin
      p = {32'd0, a} * {32'd0, b};
      case (op)
        4'd0: r = a + b;
        4'd1: r = a + ~b + 32'd1;
        4'd2: r = p[31:0];
        4'd3: r = a | b;
        4'd4: r = a & b;
        4'd5: r = a ^ b;
        default: r = '0;
      endcase
    end else begin
      for (int i = 0; i < 32; i++) begin
        case (sc)
          3'd1: r[i] = (i + s < 32) ? b[i + s] : 1'b0;
          3'd2: r[i] = (i >= s) ? b[i - s] : 1'b0;
`ifdef ALU_ROTATE_EN
          3'd3: r[i] = b[(i + s) % 32];
          3'd4: r[i] = b[(i - s + 32) % 32];
`endif
          3'd5: r[i] = (i + s < 32) ? b[i + s] : b[31];
          default: r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] sc,
                       input logic [4:0] sb, input logic [31:0] exp);
    @(negedge clk);
    opcode  = op;
    In1     = a;
    In2     = b;
    SR_Cont = sc;
    SR_Bit  = sb;
    sb_q.push_back(exp);
  endtask

  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      chk(tag, Out, sb_q.pop_front());
    end
  endtask

  task automatic op(input string tag, input logic [3:0] opc,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] sc, input logic [4:0] sb,
                    input logic [31:0] exp);
    drive(opc, a, b, sc, sb, exp);
    collect(tag);
  endtask

  logic [31:0] ror_exp;
  logic [31:0] rol_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef ALU_ROTATE_EN
    ror_exp = 32'h81234567;
    rol_exp = 32'h23456781;
`else
    ror_exp = 32'h0;
    rol_exp = 32'h0;
`endif
    rst_n   = 1'b0;
    opcode  = 4'b0000;
    In1     = 32'd15;
    In2     = 32'd20;
    SR_Cont = 3'b000;
    SR_Bit  = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", Out, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(32'd35);
    collect("reset_release");

    op("sub", 4'b0001, 32'd30, 32'd10, 3'b000, 5'd0, 32'd20);
    op("mul", 4'b0010, 32'd5, 32'd5, 3'b000, 5'd0, 32'd25);
    op("add_ovf", 4'b0000, 32'hFFFFFFFF, 32'd1, 3'b000, 5'd0, 32'd0);
    op("sub_wrap", 4'b0001, 32'd0, 32'd1, 3'b000, 5'd0, 32'hFFFFFFFF);
    op("mul_ovf", 4'b0010, 32'h10000, 32'h10000, 3'b000, 5'd0, 32'd0);
    op("or", 4'b0011, 32'h0A0, 32'h005, 3'b000, 5'd0, 32'h0A5);
    op("and", 4'b0100, 32'h0F0, 32'h00F, 3'b000, 5'd0, 32'h0);
    op("xor", 4'b0101, 32'h0FF, 32'h0F0, 3'b000, 5'd0, 32'h00F);
    op("op_0111", 4'b0111, 32'h1234, 32'h55, 3'b000, 5'd0, 32'h0);
    op("op_1111", 4'b1111, 32'h1234, 32'h55, 3'b000, 5'd0, 32'h0);

    op("srl", 4'bxxxx, 32'hFFFF, 32'h12345678, 3'b001, 5'd4, 32'h01234567);
    op("sll", 4'bxxxx, 32'hFFFF, 32'h12345678, 3'b010, 5'd4, 32'h23456780);
    op("sra", 4'bxxxx, 32'hFFFF, 32'h80000000, 3'b101, 5'd4, 32'hF8000000);
    op("sra_pos", 4'b0000, 32'h1, 32'h40000000, 3'b101, 5'd31, 32'h0);
    op("sll_31", 4'b0000, 32'h1, 32'h00000003, 3'b010, 5'd31, 32'h80000000);
    op("srl_0", 4'bxxxx, 32'h1, 32'h12345678, 3'b001, 5'd0, 32'h12345678);
    op("sll_0", 4'bxxxx, 32'h1, 32'h12345678, 3'b010, 5'd0, 32'h12345678);
    op("sra_0", 4'bxxxx, 32'h1, 32'h87654321, 3'b101, 5'd0, 32'h87654321);
    op("sh_110", 4'b0000, 32'h1, 32'h12345678, 3'b110, 5'd4, 32'h0);
    op("sh_111", 4'b0000, 32'h1, 32'h12345678, 3'b111, 5'd4, 32'h0);
    op("ror", 4'bxxxx, 32'h1, 32'h12345678, 3'b011, 5'd4, ror_exp);
    op("rol", 4'bxxxx, 32'h1, 32'h12345678, 3'b100, 5'd4, rol_exp);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      logic [3:0]  o;
      logic [2:0]  c;
      logic [4:0]  s;
      a = $urandom;
      b = $urandom;
      o = 4'($urandom_range(0, 15));
      c = 3'($urandom_range(0, 7));
      s = 5'($urandom_range(0, 31));
      op("rand", o, a, b, c, s, model(a, b, o, c, s));
    end

    op("pre_async", 4'b0000, 32'd100, 32'd23, 3'b000, 5'd0, 32'd123);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", Out, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_discard", Out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_reset", 4'b0101, 32'hF0F0F0F0, 32'hFFFF0000, 3'b000, 5'd0,
       32'h0F0FF0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
